// File: rtl/canny_pkg.sv
// canny_pkg: defaults and types shared by the Canny pipeline blocks.
//   DW_DEF    : pixel width
//   IMG_W_DEF : image width in pixels
//   IMG_H_DEF : image height in lines
//   state_e   : frame sequencing state of the window generator
package canny_pkg;
    localparam int DW_DEF    = 16;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;
endpackage

// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if: pixel stream in, 3x3 window stream out.
//   in_valid/in_data      : raster-order pixel beats, no backpressure
//   start                 : one-cycle strobe per window
//   matrix_p11..p33       : window, row-major, p22 is the centre
//   busy / frame_done     : frame in progress / end-of-frame pulse
// slave = the generator, master = the upstream/downstream environment.
interface window_gen_3x3_if import canny_pkg::*; #(
    parameter int DW = DW_DEF
) ();
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          start;
    logic [DW-1:0] matrix_p11, matrix_p12, matrix_p13;
    logic [DW-1:0] matrix_p21, matrix_p22, matrix_p23;
    logic [DW-1:0] matrix_p31, matrix_p32, matrix_p33;
    logic          busy;
    logic          frame_done;

    modport slave (
        input  in_valid, in_data,
        output start, busy, frame_done,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33
    );

    modport master (
        output in_valid, in_data,
        input  start, busy, frame_done,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33
    );
endinterface

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-entry delay line, one shift per enable.
//   clk, rst_n : clock, synchronous active-low reset (pointer only)
//   en         : shift enable
//   din        : value written on this shift
//   dout       : value written DEPTH shifts ago (read before write)
// Implemented as a circular buffer; contents are never cleared because the
// window generator masks or overwrites stale entries before use.
module line_buffer import canny_pkg::*; #(
    parameter int DEPTH = IMG_W_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] ptr_q, ptr_d;

    assign dout = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (en) ptr_d = (ptr_q == AW'(DEPTH-1)) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    always_ff @(posedge clk) begin
        if (en) mem_q[ptr_q] <= din;
    end
endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming zero-padded 3x3 neighbourhood generator.
//   clk, rst_n : clock, synchronous active-low reset
//   io (slave) : pixel beats in; start strobe, window p11..p33, busy,
//                frame_done out
// A beat is an accepted pixel (IDLE/RUN) or an internal zero pixel (FLUSH).
// Beat k completes the window centred on pixel k-IMG_W-1, so the newest
// pixel is p33; FLUSH pushes IMG_W+1 zeros to drain the last windows.
module window_gen_3x3 import canny_pkg::*; #(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic clk,
    input  logic rst_n,
    window_gen_3x3_if.slave io
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int KMAX = NPIX + IMG_W;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);

    state_e                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [XW-1:0]             x_q, x_d;
    logic [YW-1:0]             y_q, y_d;
    logic                      done_q, done_d;
    logic                      start_q, start_d;
    logic                      fdone_q, fdone_d;
    logic [0:2][0:2][DW-1:0]   win_q, win_d, raw;

    logic                      beat, emit;
    logic [DW-1:0]             pix, lb1_out, lb2_out;
    // Two registered columns per row; the third (right) column is live.
    logic [1:0][DW-1:0]        t1_q, t2_q, t3_q;

    always_comb begin
        beat = (state_q == FLUSH) ? !done_q : io.in_valid;
        pix  = (state_q == FLUSH) ? '0 : io.in_data;
        emit = beat && (k_q >= KW'(IMG_W + 1));
    end

    line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk(clk), .rst_n(rst_n), .en(beat), .din(pix), .dout(lb1_out)
    );
    line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
        .clk(clk), .rst_n(rst_n), .en(beat), .din(lb1_out), .dout(lb2_out)
    );

    always_ff @(posedge clk) begin
        if (beat) begin
            t1_q <= {t1_q[0], lb2_out};
            t2_q <= {t2_q[0], lb1_out};
            t3_q <= {t3_q[0], pix};
        end
    end

    assign raw[0] = {t1_q[1], t1_q[0], lb2_out};
    assign raw[1] = {t2_q[1], t2_q[0], lb1_out};
    assign raw[2] = {t3_q[1], t3_q[0], pix};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = done_q;
        start_d = 1'b0;
        fdone_d = 1'b0;
        win_d   = win_q;

        if (beat) k_d = (k_q == KW'(KMAX)) ? '0 : k_q + 1'b1;

        if (emit) begin
            start_d = 1'b1;
            win_d   = raw;
            if (y_q == '0)               win_d[0] = '0;
            if (y_q == YW'(IMG_H - 1))   win_d[2] = '0;
            for (int r = 0; r < 3; r++) begin
                if (x_q == '0)             win_d[r][0] = '0;
                if (x_q == XW'(IMG_W - 1)) win_d[r][2] = '0;
            end
            if (x_q == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        case (state_q)
            IDLE:  if (io.in_valid) state_d = RUN;
            RUN:   if (beat && k_q == KW'(NPIX - 1)) state_d = FLUSH;
            FLUSH: begin
                // done_q marks the cycle after the last flush beat, so
                // frame_done lines up one cycle behind the final start.
                if (done_q) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    fdone_d = 1'b1;
                end else if (k_q == KW'(KMAX)) begin
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            fdone_q <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            start_q <= start_d;
            fdone_q <= fdone_d;
            win_q   <= win_d;
        end
    end

    assign io.start      = start_q;
    assign io.busy       = (state_q != IDLE);
    assign io.frame_done = fdone_q;
    assign io.matrix_p11 = win_q[0][0];
    assign io.matrix_p12 = win_q[0][1];
    assign io.matrix_p13 = win_q[0][2];
    assign io.matrix_p21 = win_q[1][0];
    assign io.matrix_p22 = win_q[1][1];
    assign io.matrix_p23 = win_q[1][2];
    assign io.matrix_p31 = win_q[2][0];
    assign io.matrix_p32 = win_q[2][1];
    assign io.matrix_p33 = win_q[2][2];
endmodule
